// File: rtl/ram_bit_streamer.sv
// Read-side sequencer for a single-bit synchronous RAM: fetches a run of
// consecutive bits from a base address and packs them MSB-first into words.
module ram_bit_streamer #(
    parameter int ADDR_W = 10,
    parameter int WORD_W = 8,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [CNT_W-1:0]  num_words,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_we,
    output logic              ram_data,
    input  logic              ram_q,
    output logic [WORD_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready
);

    localparam int BC_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;
    localparam logic [BC_W-1:0] BIT_LAST = BC_W'(WORD_W - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        READ  = 3'd1,
        DRAIN = 3'd2,
        OUT   = 3'd3,
        DONE  = 3'd4
    } state_t;

    state_t            state_r;
    state_t            next_state_s;
    logic [ADDR_W-1:0] addr_r;
    logic [CNT_W-1:0]  word_cnt_r;
    logic [BC_W-1:0]   bit_cnt_r;
    logic              fetch_vld_r;
    logic [WORD_W-1:0] shift_r;
    logic              busy_r;
    logic              done_r;
    logic              out_valid_r;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state decode.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            IDLE: begin
                if (start) begin
                    if (num_words != {CNT_W{1'b0}}) begin
                        next_state_s = READ;
                    end else begin
                        next_state_s = DONE;
                    end
                end else begin
                    next_state_s = IDLE;
                end
            end
            READ: begin
                if (bit_cnt_r == BIT_LAST) begin
                    next_state_s = DRAIN;
                end else begin
                    next_state_s = READ;
                end
            end
            DRAIN: begin
                next_state_s = OUT;
            end
            OUT: begin
                if (out_ready) begin
                    if (word_cnt_r == CNT_W'(1)) begin
                        next_state_s = DONE;
                    end else begin
                        next_state_s = READ;
                    end
                end else begin
                    next_state_s = OUT;
                end
            end
            DONE: begin
                next_state_s = IDLE;
            end
            default: begin
                next_state_s = IDLE;
            end
        endcase
    end

    // Address, counters and job capture; only READ moves the address.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_r     <= {ADDR_W{1'b0}};
            word_cnt_r <= {CNT_W{1'b0}};
            bit_cnt_r  <= {BC_W{1'b0}};
        end else begin
            case (state_r)
                IDLE: begin
                    if (start && (num_words != {CNT_W{1'b0}})) begin
                        addr_r     <= base_addr;
                        word_cnt_r <= num_words;
                        bit_cnt_r  <= {BC_W{1'b0}};
                    end else begin
                        addr_r <= addr_r;
                    end
                end
                READ: begin
                    addr_r <= addr_r + ADDR_W'(1);
                    if (bit_cnt_r == BIT_LAST) begin
                        bit_cnt_r <= {BC_W{1'b0}};
                    end else begin
                        bit_cnt_r <= bit_cnt_r + BC_W'(1);
                    end
                end
                OUT: begin
                    if (out_ready) begin
                        word_cnt_r <= word_cnt_r - CNT_W'(1);
                    end else begin
                        word_cnt_r <= word_cnt_r;
                    end
                end
                default: begin
                    addr_r <= addr_r;
                end
            endcase
        end
    end

    // The RAM registers the address one edge after it is presented, so the
    // data bit is sampled one further edge later behind the fetch-valid flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_vld_r <= 1'b0;
            shift_r     <= {WORD_W{1'b0}};
        end else begin
            fetch_vld_r <= (state_r == READ);
            if (fetch_vld_r) begin
                shift_r <= {shift_r[WORD_W-2:0], ram_q};
            end else begin
                shift_r <= shift_r;
            end
        end
    end

    // Registered status outputs derived from the upcoming state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            out_valid_r <= 1'b0;
        end else begin
            busy_r      <= (next_state_s != IDLE);
            done_r      <= (next_state_s == DONE);
            out_valid_r <= (next_state_s == OUT);
        end
    end

    assign busy      = busy_r;
    assign done      = done_r;
    assign out_valid = out_valid_r;
    assign out_data  = shift_r;
    assign ram_addr  = addr_r;
    assign ram_we    = 1'b0;
    assign ram_data  = 1'b0;

endmodule

// File: tb/tb_ram_bit_streamer.sv
// Bench for ram_bit_streamer: behavioural RAM plus a word model computed
// directly from RAM contents, base address and word index.
module tb_ram_bit_streamer;

    localparam int ADDR_W = 10;
    localparam int WORD_W = 8;
    localparam int CNT_W  = 8;
    localparam int DEPTH  = 1 << ADDR_W;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              start;
    logic [ADDR_W-1:0] base_addr;
    logic [CNT_W-1:0]  num_words;
    logic              busy;
    logic              done;
    logic [ADDR_W-1:0] ram_addr;
    logic              ram_we;
    logic              ram_data;
    logic              ram_q;
    logic [WORD_W-1:0] out_data;
    logic              out_valid;
    logic              out_ready;

    logic              mem [0:DEPTH-1];
    logic [ADDR_W-1:0] ram_addr_q;
    logic [WORD_W-1:0] hs_q[$];
    logic [ADDR_W-1:0] addr_log[$];
    int                done_total = 0;
    int                tests_run = 0;
    int                tests_failed = 0;

    always #5 clk = ~clk;

    ram_bit_streamer #(.ADDR_W(ADDR_W), .WORD_W(WORD_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr),
        .num_words(num_words), .busy(busy), .done(done), .ram_addr(ram_addr),
        .ram_we(ram_we), .ram_data(ram_data), .ram_q(ram_q),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready)
    );

    // Synchronous RAM with registered read address.
    always @(posedge clk) ram_addr_q <= ram_addr;
    assign ram_q = mem[ram_addr_q];

    // Handshake and done monitor.
    always @(posedge clk) begin
        if (rst_n && out_valid && out_ready) hs_q.push_back(out_data);
        if (rst_n && done) done_total++;
    end

    // Log of every distinct ram_addr value.
    always @(negedge clk) begin
        if (addr_log.size() == 0 || addr_log[$] != ram_addr) addr_log.push_back(ram_addr);
    end

    function automatic logic [WORD_W-1:0] model_word(input int base, input int w);
        logic [WORD_W-1:0] r;
        for (int i = 0; i < WORD_W; i++) r[WORD_W-1-i] = mem[(base + w * WORD_W + i) % DEPTH];
        return r;
    endfunction

    task automatic fill_random();
        for (int i = 0; i < DEPTH; i++) mem[i] = 1'($urandom);
    endtask

    task automatic pulse_start(input logic [ADDR_W-1:0] b, input logic [CNT_W-1:0] n);
        @(negedge clk);
        start = 1'b1; base_addr = b; num_words = n;
        @(negedge clk);
        start = 1'b0; base_addr = ADDR_W'($urandom); num_words = CNT_W'($urandom);
    endtask

    task automatic wait_done(input int stall_pct, input int d0, output bit ok);
        ok = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            out_ready = ($urandom_range(0, 99) >= stall_pct);
            @(negedge clk);
            if (done_total > d0) begin ok = 1'b1; break; end
        end
        out_ready = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; out_ready = 1'b0;
        base_addr = '0; num_words = '0;
        for (int i = 0; i < DEPTH; i++) mem[i] = 1'b0;
        repeat (3) @(negedge clk);
        tests_run++;
        if ({busy, done, out_valid, ram_we, ram_data} !== 5'b0 || ram_addr !== '0 || out_data !== '0) begin
            tests_failed++;
            $display("FAIL reset_state: busy=%b done=%b valid=%b we=%b wd=%b addr=%0d data=%h, all required 0",
                     busy, done, out_valid, ram_we, ram_data, ram_addr, out_data);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic();
        logic [WORD_W-1:0] pat;
        logic [WORD_W-1:0] data_at_valid;
        int first_valid, first_done, d0, h0;
        bit busy_k1, busy_k12, ctl_bad;
        pat = 8'hB2;
        for (int i = 0; i < WORD_W; i++) mem[i] = pat[WORD_W-1-i];
        out_ready = 1'b1; d0 = done_total; h0 = hs_q.size();
        first_valid = -1; first_done = -1; data_at_valid = '0;
        busy_k1 = 1'b0; busy_k12 = 1'b1; ctl_bad = 1'b0;
        @(negedge clk);
        start = 1'b1; base_addr = '0; num_words = 8'd1;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (k == 1) begin start = 1'b0; busy_k1 = busy; end
            if (k == 12) busy_k12 = busy;
            if (out_valid && first_valid < 0) begin first_valid = k; data_at_valid = out_data; end
            if (done && first_done < 0) first_done = k;
            if (ram_we !== 1'b0 || ram_data !== 1'b0) ctl_bad = 1'b1;
        end
        tests_run++;
        if (first_valid !== 10) begin tests_failed++; $display("FAIL basic_latency: valid after %0d cycles, required 10", first_valid); end
        tests_run++;
        if (data_at_valid !== 8'hB2) begin tests_failed++; $display("FAIL basic_data: got %h required b2", data_at_valid); end
        tests_run++;
        if (first_done !== 11) begin tests_failed++; $display("FAIL basic_done_time: done at %0d required 11", first_done); end
        tests_run++;
        if (busy_k1 !== 1'b1 || busy_k12 !== 1'b0) begin tests_failed++; $display("FAIL basic_busy: k1=%b k12=%b required 1,0", busy_k1, busy_k12); end
        tests_run++;
        if (hs_q.size() - h0 != 1 || done_total - d0 != 1) begin
            tests_failed++; $display("FAIL basic_counts: words=%0d done=%0d required 1,1", hs_q.size() - h0, done_total - d0);
        end
        tests_run++;
        if (ctl_bad) begin tests_failed++; $display("FAIL ram_write_port: we/data went nonzero, required constant 0"); end
    endtask

    task automatic test_backpressure();
        logic [15:0] pat;
        logic [ADDR_W-1:0] a0;
        int d0, h0;
        bit ok, seen;
        pat = 16'hA53C;
        for (int i = 0; i < 16; i++) mem[16 + i] = pat[15-i];
        out_ready = 1'b0; d0 = done_total; h0 = hs_q.size();
        pulse_start(10'd16, 8'd2);
        seen = 1'b0;
        for (int c = 0; c < 40; c++) begin
            if (out_valid) begin seen = 1'b1; break; end
            @(negedge clk);
        end
        tests_run++;
        if (!seen) begin tests_failed++; $display("FAIL bp_valid_timeout: out_valid=0 after 40 cycles, required 1"); end
        a0 = ram_addr;
        tests_run++;
        if (a0 !== 10'd24) begin tests_failed++; $display("FAIL bp_addr_after_word: got %0d required 24", a0); end
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            tests_run++;
            if (out_data !== 8'hA5 || out_valid !== 1'b1 || ram_addr !== a0) begin
                tests_failed++;
                $display("FAIL bp_stall: data=%h valid=%b addr=%0d required a5,1,%0d", out_data, out_valid, ram_addr, a0);
            end
        end
        wait_done(0, d0, ok);
        tests_run++;
        if (!ok) begin tests_failed++; $display("FAIL bp_done_timeout: no done, required 1"); end
        tests_run++;
        if (hs_q.size() - h0 != 2 || done_total - d0 != 1) begin
            tests_failed++; $display("FAIL bp_counts: words=%0d done=%0d required 2,1", hs_q.size() - h0, done_total - d0);
        end else begin
            tests_run++;
            if (hs_q[h0] !== 8'hA5 || hs_q[h0+1] !== 8'h3C) begin
                tests_failed++; $display("FAIL bp_words: got %h %h required a5 3c", hs_q[h0], hs_q[h0+1]);
            end
        end
    endtask

    task automatic test_wrap();
        int l0, h0, d0;
        bit ok;
        for (int i = 0; i < 4; i++) begin mem[1020 + i] = 1'b1; mem[i] = 1'b0; end
        l0 = addr_log.size(); h0 = hs_q.size(); d0 = done_total;
        pulse_start(10'd1020, 8'd1);
        wait_done(40, d0, ok);
        tests_run++;
        if (!ok || hs_q.size() - h0 != 1) begin
            tests_failed++; $display("FAIL wrap_done: done_seen=%b words=%0d required 1,1", ok, hs_q.size() - h0);
        end else begin
            tests_run++;
            if (hs_q[h0] !== 8'hF0) begin tests_failed++; $display("FAIL wrap_data: got %h required f0", hs_q[h0]); end
        end
        tests_run++;
        if (addr_log.size() - l0 != 9) begin
            tests_failed++; $display("FAIL wrap_addr_count: %0d address changes, required 9", addr_log.size() - l0);
        end else begin
            for (int i = 0; i < 9; i++) begin
                tests_run++;
                if (addr_log[l0 + i] !== ADDR_W'((1020 + i) % DEPTH)) begin
                    tests_failed++;
                    $display("FAIL wrap_addr_seq: step %0d got %0d required %0d", i, addr_log[l0 + i], (1020 + i) % DEPTH);
                end
            end
        end
    endtask

    task automatic test_empty();
        logic [ADDR_W-1:0] a0;
        int d0, h0;
        bit valid_seen;
        a0 = ram_addr; d0 = done_total; h0 = hs_q.size(); valid_seen = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        start = 1'b1; base_addr = 10'd777; num_words = 8'd0;
        @(negedge clk);
        start = 1'b0;
        tests_run++;
        if (done !== 1'b1 || busy !== 1'b1) begin tests_failed++; $display("FAIL empty_done: done=%b busy=%b required 1,1", done, busy); end
        @(negedge clk);
        tests_run++;
        if (done !== 1'b0 || busy !== 1'b0) begin tests_failed++; $display("FAIL empty_after: done=%b busy=%b required 0,0", done, busy); end
        for (int c = 0; c < 5; c++) begin
            if (out_valid) valid_seen = 1'b1;
            @(negedge clk);
        end
        tests_run++;
        if (valid_seen || ram_addr !== a0 || hs_q.size() != h0 || done_total - d0 != 1) begin
            tests_failed++;
            $display("FAIL empty_side_effects: valid=%b addr=%0d words=%0d dones=%0d required 0,%0d,%0d,1",
                     valid_seen, ram_addr, hs_q.size() - h0, done_total - d0, a0, 0);
        end
    endtask

    task automatic test_start_while_busy();
        logic [ADDR_W-1:0] ba, bb;
        int d0, h0;
        bit ok;
        fill_random();
        ba = ADDR_W'($urandom); bb = ba + 10'd333;
        d0 = done_total; h0 = hs_q.size();
        pulse_start(ba, 8'd2);
        repeat (2) @(negedge clk);
        pulse_start(bb, 8'd1);
        wait_done(30, d0, ok);
        repeat (20) @(negedge clk);
        tests_run++;
        if (!ok || hs_q.size() - h0 != 2 || done_total - d0 != 1 || busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL busy_start_counts: words=%0d dones=%0d busy=%b required 2,1,0", hs_q.size() - h0, done_total - d0, busy);
        end else begin
            for (int w = 0; w < 2; w++) begin
                tests_run++;
                if (hs_q[h0 + w] !== model_word(ba, w)) begin
                    tests_failed++; $display("FAIL busy_start_word%0d: got %h required %h", w, hs_q[h0 + w], model_word(ba, w));
                end
            end
        end
    endtask

    task automatic test_random_jobs(input int iters);
        logic [ADDR_W-1:0] b;
        logic [CNT_W-1:0] n;
        int d0, h0, stall;
        bit ok;
        for (int it = 0; it < iters; it++) begin
            fill_random();
            b = ADDR_W'($urandom); n = CNT_W'($urandom_range(1, 4)); stall = $urandom_range(0, 60);
            d0 = done_total; h0 = hs_q.size();
            pulse_start(b, n);
            wait_done(stall, d0, ok);
            tests_run++;
            if (!ok || hs_q.size() - h0 != int'(n) || done_total - d0 != 1) begin
                tests_failed++;
                $display("FAIL rand_counts[%0d]: words=%0d dones=%0d required %0d,1", it, hs_q.size() - h0, done_total - d0, n);
            end else begin
                for (int w = 0; w < int'(n); w++) begin
                    tests_run++;
                    if (hs_q[h0 + w] !== model_word(b, w)) begin
                        tests_failed++;
                        $display("FAIL rand_word[%0d.%0d]: base=%0d got %h required %h", it, w, b, hs_q[h0 + w], model_word(b, w));
                    end
                end
            end
        end
    endtask

    task automatic test_reset_midjob();
        int d0, h0;
        bit seen;
        fill_random();
        out_ready = 1'b0;
        pulse_start(ADDR_W'($urandom), 8'd2);
        seen = 1'b0;
        for (int c = 0; c < 40; c++) begin
            if (out_valid) begin seen = 1'b1; break; end
            @(negedge clk);
        end
        tests_run++;
        if (!seen) begin tests_failed++; $display("FAIL rst_mid_valid_timeout: out_valid=0, required 1"); end
        #2;
        rst_n = 1'b0;
        #1;
        tests_run++;
        if ({busy, done, out_valid} !== 3'b0 || ram_addr !== '0 || out_data !== '0) begin
            tests_failed++;
            $display("FAIL rst_mid_async: busy=%b done=%b valid=%b addr=%0d data=%h required all 0",
                     busy, done, out_valid, ram_addr, out_data);
        end
        @(negedge clk);
        rst_n = 1'b1; out_ready = 1'b1;
        d0 = done_total; h0 = hs_q.size();
        repeat (20) @(negedge clk);
        tests_run++;
        if (done_total != d0 || hs_q.size() != h0 || busy !== 1'b0 || out_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL rst_mid_after: dones=%0d words=%0d busy=%b valid=%b required 0,0,0,0",
                     done_total - d0, hs_q.size() - h0, busy, out_valid);
        end
        test_random_jobs(1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_wrap();
        test_empty();
        test_start_while_busy();
        test_random_jobs(6);
        test_reset_midjob();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
